// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM arbiter and its round-robin helper.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time wins.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // pick a winner; gnt stays zero when disabled or nobody asks
  always_comb begin
    gnt    = 2'b00;
    gnt_id = PORT_A;
    if (req[0] && req[1]) gnt_id = ~last;
    else if (req[1])      gnt_id = PORT_B;
    else                  gnt_id = PORT_A;
    if (en && (req != 2'b00)) gnt = (gnt_id == PORT_B) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin front end for a single-port RAM, with optional
// clear-on-reset. One RAM access at a time; req/ack handshake per port.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_write,
  output logic              ram_select,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                win_q, win_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                ram_write_q, ram_write_d;
  logic                ram_select_q, ram_select_d;
  logic                init_done_q, init_done_d;

  logic [1:0]          gnt;
  logic                gnt_id;

  // arbitration only counts in IDLE once the clear has finished
  rr_arb2 u_arb (
    .req    ({b_req, a_req}),
    .last   (last_q),
    .en     (init_done_q && (state_q == ST_IDLE)),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_write_d  = 1'b0;
    ram_select_d = 1'b0;
    init_done_d  = init_done_q;
    case (state_q)
      ST_INIT: begin
        // the cycle writing the top address is in flight: finish the clear
        if (ram_select_q && (ram_addr_q == {ADDR_W{1'b1}})) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          ram_addr_d   = cnt_q;
          ram_din_d    = '0;
          ram_write_d  = 1'b1;
          ram_select_d = 1'b1;
          cnt_d        = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        init_done_d = 1'b1;
        if (gnt != 2'b00) begin
          ram_addr_d   = (gnt_id == PORT_B) ? b_addr  : a_addr;
          ram_din_d    = (gnt_id == PORT_B) ? b_wdata : a_wdata;
          ram_write_d  = (gnt_id == PORT_B) ? b_we    : a_we;
          ram_select_d = 1'b1;
          win_d        = gnt_id;
          last_d       = gnt_id;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // RAM read data is combinational, capture it as the access closes
        if (win_q == PORT_B) begin
          b_ack_d = 1'b1;
          if (!ram_write_q) b_rdata_d = ram_dout;
        end else begin
          a_ack_d = 1'b1;
          if (!ram_write_q) a_rdata_d = ram_dout;
        end
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      last_q       <= PORT_B;
      win_q        <= PORT_A;
      cnt_q        <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_write_q  <= 1'b0;
      ram_select_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_write_q  <= ram_write_d;
      ram_select_q <= ram_select_d;
      init_done_q  <= init_done_d;
    end
  end

  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign init_done  = init_done_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_write  = ram_write_q;
  assign ram_select = ram_select_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance with clear-on-reset, one without.
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance with clear-on-reset
  logic       rst, a_req, a_we, b_req, b_we, a_ack, b_ack, init_done;
  logic [9:0] a_addr, b_addr, ram_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_din, ram_dout;
  logic       ram_write, ram_select;
  // instance without clear
  logic       z_rst, z_a_req, z_a_we, z_b_req, z_b_we, z_a_ack, z_b_ack, z_init_done;
  logic [9:0] z_a_addr, z_b_addr, z_ram_addr;
  logic [7:0] z_a_wdata, z_b_wdata, z_a_rdata, z_b_rdata, z_ram_din, z_ram_dout;
  logic       z_ram_write, z_ram_select;

  ram_arbiter #(.ADDR_W(10), .DATA_W(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .init_done(init_done), .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write),
    .ram_select(ram_select), .ram_dout(ram_dout));

  ram_arbiter #(.ADDR_W(10), .DATA_W(8), .CLEAR_ON_RESET(1'b0)) dut_z (
    .clk(clk), .rst(z_rst),
    .a_req(z_a_req), .a_we(z_a_we), .a_addr(z_a_addr), .a_wdata(z_a_wdata), .a_ack(z_a_ack), .a_rdata(z_a_rdata),
    .b_req(z_b_req), .b_we(z_b_we), .b_addr(z_b_addr), .b_wdata(z_b_wdata), .b_ack(z_b_ack), .b_rdata(z_b_rdata),
    .init_done(z_init_done), .ram_addr(z_ram_addr), .ram_din(z_ram_din), .ram_write(z_ram_write),
    .ram_select(z_ram_select), .ram_dout(z_ram_dout));

  // RAM models: synchronous write, combinational read; pre loads a fill value
  logic       pre;
  logic [7:0] mem   [0:1023];
  logic [7:0] z_mem [0:1023];
  always @(posedge clk) begin
    if (pre) for (int i = 0; i < 1024; i++) mem[i] <= 8'hFF;
    else if (ram_select && ram_write) mem[ram_addr] <= ram_din;
  end
  always @(posedge clk) begin
    if (pre) for (int i = 0; i < 1024; i++) z_mem[i] <= 8'h11;
    else if (z_ram_select && z_ram_write) z_mem[z_ram_addr] <= z_ram_din;
  end
  assign ram_dout   = (ram_select && !ram_write) ? mem[ram_addr] : 8'h00;
  assign z_ram_dout = (z_ram_select && !z_ram_write) ? z_mem[z_ram_addr] : 8'h00;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // one port-A transaction; reports rdata at ack, edges to ack, B activity, ack one cycle later
  task automatic a_txn(input logic we, input logic [9:0] ad, input logic [7:0] wd,
                       output logic [7:0] rd, output int lat, output bit bseen, output logic ack_after);
    @(negedge clk);
    a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
    lat = 0; bseen = 1'b0;
    do begin
      @(posedge clk); #1; lat++;
      if (b_ack) bseen = 1'b1;
    end while (!a_ack && lat < 20);
    rd = a_rdata;
    a_req = 1'b0;
    @(posedge clk); #1;
    ack_after = a_ack;
    if (b_ack) bseen = 1'b1;
    if (lat >= 20) chk("a_timeout", 0, 1);
  endtask

  // watch acks on both ports; hold=0 drops each port's req after its ack
  int         ord [0:7];
  int         at  [0:7];
  int         got;
  bit         ovl;
  logic [7:0] b_rd;
  task automatic collect(input int nacks, input bit hold);
    int c = 0;
    got = 0; ovl = 1'b0;
    while (got < nacks && c < 60) begin
      @(posedge clk); #1; c++;
      if (a_ack && b_ack) ovl = 1'b1;
      if (a_ack) begin ord[got] = 0; at[got] = c; got++; if (!hold) a_req = 1'b0; end
      if (b_ack) begin ord[got] = 1; at[got] = c; got++; b_rd = b_rdata; if (!hold) b_req = 1'b0; end
    end
    a_req = 1'b0; b_req = 1'b0;
    if (got < nacks) chk("collect_timeout", got, nacks);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [0:5];
    vec_t       bnd [0:3];
    logic [7:0] rd;
    int         lat, n, acks, bad;
    bit         bs;
    logic       aw;

    // port A transactions; writes expect rdata to hold the previous read
    tbl[0] = '{1'b1, 10'h3FF, 8'h5A, 8'h00};
    tbl[1] = '{1'b0, 10'h3FF, 8'h00, 8'h5A};
    tbl[2] = '{1'b1, 10'h000, 8'hA5, 8'h5A};
    tbl[3] = '{1'b0, 10'h000, 8'h00, 8'hA5};
    tbl[4] = '{1'b1, 10'h1FF, 8'h3C, 8'hA5};
    tbl[5] = '{1'b0, 10'h1FF, 8'h00, 8'h3C};
    // reads after the (2*k)%256 fill
    bnd[0] = '{1'b0, 10'd0,    8'h00, 8'h00};
    bnd[1] = '{1'b0, 10'd1,    8'h00, 8'h02};
    bnd[2] = '{1'b0, 10'd1022, 8'h00, 8'hFC};
    bnd[3] = '{1'b0, 10'd1023, 8'h00, 8'hFE};

    pre = 1'b1; rst = 1'b1; z_rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    z_a_req = 0; z_a_we = 0; z_a_addr = 0; z_a_wdata = 0; z_b_req = 0; z_b_we = 0; z_b_addr = 0; z_b_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_select", ram_select, 0);
    chk("rst_outs", {a_ack, b_ack, ram_write, ram_addr, ram_din, a_rdata, b_rdata}, 0);

    // clear sequence with A requesting throughout
    @(negedge clk);
    pre = 1'b0; rst = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'd5;
    @(posedge clk);
    n = 0; acks = 0;
    while (n < 1100) begin
      @(posedge clk); #1; n++;
      if (a_ack) acks++;
      if (init_done) break;
    end
    a_req = 1'b0;
    chk("init_edges", n, 1024);
    chk("init_no_ack", acks, 0);

    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      a_txn(1'b0, i[9:0], 8'h00, rd, lat, bs, aw);
      if (rd !== 8'h00) bad++;
    end
    chk("clear_readback_bad", bad, 0);

    for (int i = 0; i < 6; i++) begin
      a_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, lat, bs, aw);
      chk($sformatf("vec%0d_lat", i), lat, 2);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
      chk($sformatf("vec%0d_ack_width", i), aw, 0);
      chk($sformatf("vec%0d_b_quiet", i), bs, 0);
    end

    // single B read makes B the last winner so A takes the next tie
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h3FF;
    collect(1, 1'b0);
    chk("b_single_port", ord[0], 1);
    chk("b_single_rdata", b_rd, 8'h5A);

    // tie: A writes addr 10, B reads it back
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd10; a_wdata = 8'h9D;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'd10;
    collect(2, 1'b0);
    chk("pair_first", ord[0], 0);
    chk("pair_second", ord[1], 1);
    chk("pair_b_rdata", b_rd, 8'h9D);

    // both ports hammer: strict alternation, one ack every 3 cycles
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd30; a_wdata = 8'h01;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'd31;
    collect(6, 1'b1);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), ord[i], i % 2);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_gap%0d", i), at[i+1] - at[i], 3);
    chk("rr_overlap", ovl, 0);

    // (2*k)%256 fill then boundary reads
    for (int i = 0; i < 1024; i++) a_txn(1'b1, i[9:0], 8'((2 * i) % 256), rd, lat, bs, aw);
    for (int i = 0; i < 4; i++) begin
      a_txn(bnd[i].we, bnd[i].addr, bnd[i].wdata, rd, lat, bs, aw);
      chk($sformatf("bnd%0d_rdata", i), rd, bnd[i].exp);
    end

    // no-clear instance: reset lands during a B write access
    @(negedge clk);
    z_rst = 1'b0;
    @(posedge clk); #1;
    chk("z_init_first_edge", z_init_done, 1);
    @(negedge clk);
    z_b_req = 1'b1; z_b_we = 1'b1; z_b_addr = 10'd20; z_b_wdata = 8'hC3;
    @(posedge clk); #1;
    chk("z_access_sel", {z_ram_select, z_ram_write}, 2'b11);
    @(negedge clk);
    z_rst = 1'b1; z_b_req = 1'b0;
    @(posedge clk); #1;
    chk("z_rst_b_ack", z_b_ack, 0);
    chk("z_rst_outs", {z_a_ack, z_init_done, z_ram_select, z_ram_write, z_ram_addr, z_ram_din, z_a_rdata, z_b_rdata}, 0);
    @(negedge clk);
    z_rst = 1'b0;
    @(posedge clk); #1;
    chk("z_init_again", z_init_done, 1);
    // the RAM saw select+write during the aborted cycle, so the word landed
    @(negedge clk);
    z_a_req = 1'b1; z_a_we = 1'b0; z_a_addr = 10'd20;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!z_a_ack && n < 20);
    z_a_req = 1'b0;
    chk("z_read_lat", n, 2);
    chk("z_read_rdata", z_a_rdata, 8'hC3);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
